cpu_mem_responder: RTL and testbench



---
 rtl/cpu_mem_responder.sv | 145 ++++++++++++++
 tb/tb_cpu_mem_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Memory-side responder for the 16-bit CPU bus: zero-fills a word RAM after reset,
// takes a program image over a load stream, then serves CPU reads/byte-lane writes.
module cpu_mem_responder #(
    parameter int          DEPTH   = 256,
    parameter int          ADDR_W  = 8,
    parameter logic [15:0] IO_ADDR = 16'hFFFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] adr,
    input  logic [15:0] wdata,
    input  logic        memwrite_a,
    input  logic        memwrite_b,
    output logic [15:0] memdata,
    input  logic        ld_valid,
    input  logic [15:0] ld_data,
    input  logic        ld_last,
    output logic        ld_ready,
    output logic        cpu_run,
    output logic [15:0] io_out,
    output logic        io_strobe,
    output logic [1:0]  dbg_state
);

    // Load stream handshake: a word transfers on any rising edge where
    // ld_valid && ld_ready; ld_ready is high only in LOAD, ld_last is ignored unless ld_valid.
    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_LOAD  = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [15:0]       r_mem [DEPTH];
    logic [15:0]       r_memdata;
    logic [15:0]       r_io_out;
    logic              r_io_strobe;

    logic              w_ram_hit;
    logic              w_io_hit;
    logic              w_bus_we;
    logic              w_mem_we_lo;
    logic              w_mem_we_hi;
    logic [ADDR_W-1:0] w_mem_waddr;
    logic [15:0]       w_mem_wdata;

    // Full 16-bit compare so aliases above DEPTH never reach the RAM.
    assign w_ram_hit = ({16'd0, adr} < 32'(DEPTH));
    assign w_io_hit  = (adr == IO_ADDR);
    assign w_bus_we  = memwrite_a | memwrite_b;

    assign ld_ready  = (r_state == S_LOAD);
    assign cpu_run   = (r_state == S_RUN);
    assign memdata   = r_memdata;
    assign io_out    = r_io_out;
    assign io_strobe = r_io_strobe;
    assign dbg_state = r_state;

    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_mem_we_lo = 1'b0;
        w_mem_we_hi = 1'b0;
        w_mem_waddr = r_ptr;
        w_mem_wdata = 16'h0000;
        case (r_state)
            S_CLEAR: begin
                w_mem_we_lo = 1'b1;
                w_mem_we_hi = 1'b1;
                if (r_ptr == LAST_PTR) begin
                    w_ptr_nxt   = '0;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_ptr_nxt = r_ptr + 1'b1;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    w_mem_we_lo = 1'b1;
                    w_mem_we_hi = 1'b1;
                    w_mem_wdata = ld_data;
                    // The final slot ends the load without wrapping the pointer.
                    if (ld_last || (r_ptr == LAST_PTR)) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_ptr_nxt = r_ptr + 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_ram_hit) begin
                    w_mem_we_lo = memwrite_a;
                    w_mem_we_hi = memwrite_b;
                    w_mem_waddr = adr[ADDR_W-1:0];
                    w_mem_wdata = wdata;
                end
            end
            default: begin
                w_state_nxt = S_CLEAR;
                w_ptr_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_CLEAR;
            r_ptr       <= '0;
            r_memdata   <= 16'h0000;
            r_io_out    <= 16'h0000;
            r_io_strobe <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_ptr       <= w_ptr_nxt;
            r_io_strobe <= (r_state == S_RUN) && w_io_hit && w_bus_we;
            if ((r_state == S_RUN) && w_io_hit) begin
                if (memwrite_a) r_io_out[7:0]  <= wdata[7:0];
                if (memwrite_b) r_io_out[15:8] <= wdata[15:8];
            end
            // Read-first: the RAM and io_out values sampled here predate this edge's write.
            if (r_state == S_RUN) begin
                if (w_ram_hit) begin
                    r_memdata <= r_mem[adr[ADDR_W-1:0]];
                end else if (w_io_hit) begin
                    r_memdata <= r_io_out;
                end else begin
                    r_memdata <= 16'h0000;
                end
            end else begin
                r_memdata <= 16'h0000;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset && w_mem_we_lo) r_mem[w_mem_waddr][7:0]  <= w_mem_wdata[7:0];
        if (reset && w_mem_we_hi) r_mem[w_mem_waddr][15:8] <= w_mem_wdata[15:8];
    end

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Bench for cpu_mem_responder: directed steps plus random bus traffic checked
// against a word-array model of RAM and the IO register.
module tb_cpu_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] adr;
    logic [15:0] wdata;
    logic        memwrite_a;
    logic        memwrite_b;
    logic [15:0] memdata;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;
    logic        ld_ready;
    logic        cpu_run;
    logic [15:0] io_out;
    logic        io_strobe;
    logic [1:0]  dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] m_mem [256];
    logic [15:0] m_io;

    cpu_mem_responder dut (
        .clk        (clk),
        .reset      (reset),
        .adr        (adr),
        .wdata      (wdata),
        .memwrite_a (memwrite_a),
        .memwrite_b (memwrite_b),
        .memdata    (memdata),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_last    (ld_last),
        .ld_ready   (ld_ready),
        .cpu_run    (cpu_run),
        .io_out     (io_out),
        .io_strobe  (io_strobe),
        .dbg_state  (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] m_read(input logic [15:0] a);
        if (a < 16'd256) return m_mem[a[7:0]];
        if (a == 16'hFFFF) return m_io;
        return 16'h0000;
    endfunction

    task automatic m_write(input logic [15:0] a, input logic [15:0] d, input logic wa, input logic wb);
        if (a < 16'd256) begin
            if (wa) m_mem[a[7:0]][7:0]  = d[7:0];
            if (wb) m_mem[a[7:0]][15:8] = d[15:8];
        end else if (a == 16'hFFFF) begin
            if (wa) m_io[7:0]  = d[7:0];
            if (wb) m_io[15:8] = d[15:8];
        end
    endtask

    // One bus cycle in RUN: read data is the value before any same-edge write.
    task automatic bus_op(input logic [15:0] a, input logic [15:0] d,
                          input logic wa, input logic wb, input string tag);
        logic [15:0] exp_rd;
        logic        exp_stb;
        exp_rd  = m_read(a);
        exp_stb = (a == 16'hFFFF) && (wa || wb);
        m_write(a, d, wa, wb);
        adr        = a;
        wdata      = d;
        memwrite_a = wa;
        memwrite_b = wb;
        tick();
        memwrite_a = 1'b0;
        memwrite_b = 1'b0;
        check({tag, " memdata"}, memdata, exp_rd);
        check({tag, " io_strobe"}, {15'd0, io_strobe}, {15'd0, exp_stb});
        check({tag, " io_out"}, io_out, m_io);
    endtask

    task automatic apply_reset(input int cycles);
        reset      = 1'b0;
        ld_valid   = 1'b0;
        ld_last    = 1'b0;
        memwrite_a = 1'b0;
        memwrite_b = 1'b0;
        for (int i = 0; i < cycles; i++) tick();
        check("rst cpu_run", {15'd0, cpu_run}, 16'd0);
        check("rst ld_ready", {15'd0, ld_ready}, 16'd0);
        check("rst memdata", memdata, 16'h0000);
        check("rst io_out", io_out, 16'h0000);
        check("rst io_strobe", {15'd0, io_strobe}, 16'd0);
        for (int i = 0; i < 256; i++) m_mem[i] = 16'h0000;
        m_io  = 16'h0000;
        reset = 1'b1;
    endtask

    // Counts edges after reset release until ld_ready rises; CLEAR must take 256.
    task automatic wait_clear(input string tag);
        int   n;
        logic run_seen;
        n        = 0;
        run_seen = 1'b0;
        while (!ld_ready && n < 600) begin
            tick();
            n++;
            if (cpu_run) run_seen = 1'b1;
        end
        check({tag, " clear cycles"}, 16'(n), 16'd256);
        check({tag, " cpu_run during clear"}, {15'd0, run_seen}, 16'd0);
    endtask

    task automatic load_word(input int idx, input logic [15:0] d, input logic last,
                             input logic exp_run, input string tag);
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 16'($urandom);
        m_mem[idx] = d;
        check({tag, " cpu_run"}, {15'd0, cpu_run}, {15'd0, exp_run});
    endtask

    initial begin
        logic [15:0] a;
        logic [15:0] first_w;
        logic [15:0] d;
        int          sel;

        adr   = 16'h0000;
        wdata = 16'h0000;
        ld_data = 16'h0000;

        // Reset and CLEAR timing.
        apply_reset(2);
        check("rst dbg_state", {14'd0, dbg_state}, 16'd0);
        wait_clear("boot");

        // Short load with a gap; bus activity during LOAD must not touch RAM.
        load_word(0, 16'h1111, 1'b0, 1'b0, "ld0");
        load_word(1, 16'h2222, 1'b0, 1'b0, "ld1");
        adr = 16'h0000; wdata = 16'hFFFF; memwrite_a = 1'b1; memwrite_b = 1'b1;
        tick();
        memwrite_a = 1'b0; memwrite_b = 1'b0;
        check("gap ld_ready", {15'd0, ld_ready}, 16'd1);
        check("gap cpu_run", {15'd0, cpu_run}, 16'd0);
        check("gap memdata", memdata, 16'h0000);
        load_word(2, 16'h3333, 1'b1, 1'b1, "ld2");
        check("run ld_ready", {15'd0, ld_ready}, 16'd0);
        for (int i = 0; i < 4; i++) bus_op(16'(i), 16'h0000, 1'b0, 1'b0, "rd_img");

        // Byte lanes and read-first.
        bus_op(16'd5, 16'hABCD, 1'b1, 1'b1, "w5_full");
        bus_op(16'd5, 16'h1234, 1'b1, 1'b0, "w5_lo");
        bus_op(16'd5, 16'h0000, 1'b0, 1'b0, "rd5_lo");
        check("byte lo value", m_mem[5], 16'hAB34);
        bus_op(16'd5, 16'h5600, 1'b0, 1'b1, "w5_hi");
        bus_op(16'd5, 16'h0000, 1'b0, 1'b0, "rd5_hi");
        bus_op(16'd5, 16'h9999, 1'b1, 1'b1, "rdw5");
        bus_op(16'd5, 16'h0000, 1'b0, 1'b0, "rd5_new");

        // IO register, strobe width, out-of-range writes.
        bus_op(16'hFFFF, 16'hBEEF, 1'b1, 1'b1, "io_w");
        bus_op(16'h0000, 16'h0000, 1'b0, 1'b0, "io_idle");
        bus_op(16'hFFFF, 16'h0000, 1'b0, 1'b0, "io_rd");
        bus_op(16'hFFFF, 16'h0012, 1'b1, 1'b0, "io_b2b0");
        bus_op(16'hFFFF, 16'h3400, 1'b0, 1'b1, "io_b2b1");
        bus_op(16'h0400, 16'hDEAD, 1'b1, 1'b1, "oor_w");
        bus_op(16'h0400, 16'h0000, 1'b0, 1'b0, "oor_rd");
        bus_op(16'h0000, 16'h0000, 1'b0, 1'b0, "alias_rd0");

        // Random bus traffic.
        for (int i = 0; i < 300; i++) begin
            sel = $urandom_range(0, 9);
            if (sel <= 5)      a = 16'($urandom_range(0, 255));
            else if (sel == 6) a = 16'hFFFF;
            else if (sel == 7) a = 16'($urandom_range(256, 65534));
            else if (sel == 8) a = {8'($urandom_range(1, 255)), 8'($urandom)};
            else               a = 16'($urandom_range(0, 15));
            bus_op(a, 16'($urandom), 1'($urandom), 1'($urandom), "rand");
        end

        // Full-depth load without ld_last.
        apply_reset(2);
        wait_clear("full");
        first_w = 16'h0000;
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(0, 3) == 0) tick();
            d = 16'($urandom);
            if (i == 0) first_w = d;
            load_word(i, d, 1'b0, (i == 255), "full_ld");
        end
        check("full ld_ready", {15'd0, ld_ready}, 16'd0);
        check("full first word", m_mem[0], first_w);
        bus_op(16'd0, 16'h0000, 1'b0, 1'b0, "full_rd0");
        bus_op(16'd255, 16'h0000, 1'b0, 1'b0, "full_rd255");
        for (int i = 0; i < 20; i++)
            bus_op(16'($urandom_range(0, 255)), 16'h0000, 1'b0, 1'b0, "full_rdr");

        // Reset in the middle of LOAD discards the partial image.
        apply_reset(2);
        wait_clear("mid1");
        for (int i = 0; i < 10; i++) load_word(i, 16'($urandom) | 16'h0001, 1'b0, 1'b0, "mid_ld");
        apply_reset(1);
        wait_clear("mid2");
        load_word(0, 16'hC0DE, 1'b1, 1'b1, "mid_one");
        bus_op(16'd1, 16'h0000, 1'b0, 1'b0, "mid_rd1");
        bus_op(16'd0, 16'h0000, 1'b0, 1'b0, "mid_rd0");
        bus_op(16'd5, 16'h0000, 1'b0, 1'b0, "mid_rd5");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
